// File: rtl/palette_lut_fx_if.sv
// ------------------------------------------------------------------
// palette_lut_fx_if : lookup, write and fade bus for palette_lut_fx
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface palette_lut_fx_if #(
  parameter int IDX_W     = 4,
  parameter int NUM_BANKS = 2,
  parameter int CW        = 4,
  parameter int LVL_W     = 4
);
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                pix_valid;
  logic [BANK_W-1:0]   pix_bank;
  logic [IDX_W-1:0]    pix_index;
  logic                wr_en;
  logic [BANK_W-1:0]   wr_bank;
  logic [IDX_W-1:0]    wr_index;
  logic [3*CW-1:0]     wr_rgb;
  logic                frame_tick;
  logic                fade_out_req;
  logic                fade_in_req;

  logic                out_valid;
  logic [CW-1:0]       red;
  logic [CW-1:0]       green;
  logic [CW-1:0]       blue;
  logic                transparent;
  logic [LVL_W:0]      level;
  logic                fade_busy;
  logic                fade_done;

  modport master (
    output pix_valid, pix_bank, pix_index,
    output wr_en, wr_bank, wr_index, wr_rgb,
    output frame_tick, fade_out_req, fade_in_req,
    input  out_valid, red, green, blue, transparent,
    input  level, fade_busy, fade_done
  );

  modport slave (
    input  pix_valid, pix_bank, pix_index,
    input  wr_en, wr_bank, wr_index, wr_rgb,
    input  frame_tick, fade_out_req, fade_in_req,
    output out_valid, red, green, blue, transparent,
    output level, fade_busy, fade_done
  );
endinterface

`default_nettype wire

// File: rtl/palette_lut_fx.sv
// ------------------------------------------------------------------
// palette_lut_fx : multi-bank palette RAM, 2-stage lookup, fade engine
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module palette_lut_fx #(
  parameter int IDX_W      = 4,
  parameter int NUM_BANKS  = 2,
  parameter int CW         = 4,
  parameter int LVL_W      = 4,
  parameter int FADE_DIV   = 2,
  parameter int TRANSP_EN  = 1,
  parameter int TRANSP_IDX = 0
) (
  input  logic           Clk,
  input  logic           Reset_n,
  palette_lut_fx_if.slave bus
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RGB_W  = 3 * CW;
  localparam int ADDR_W = BANK_W + IDX_W;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int TICK_W = (FADE_DIV > 1) ? $clog2(FADE_DIV + 1) : 1;
  localparam logic [LVL_W:0] LVL_FULL = {1'b1, {LVL_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c,
                                          input logic [LVL_W:0] l);
    logic [CW+LVL_W:0] p;
    p = {{(LVL_W+1){1'b0}}, c} * {{CW{1'b0}}, l};
    return CW'(p >> LVL_W);
  endfunction

  // ---------------- palette RAM ----------------
  // Flat {bank,index} addressing; banks beyond NUM_BANKS are never written.
  logic [RGB_W-1:0]  mem [DEPTH];
  logic              wr_bank_ok;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_bank_ok = 32'(bus.wr_bank) < NUM_BANKS;
  assign wr_addr    = {bus.wr_bank, bus.wr_index};

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.wr_en && wr_bank_ok) begin
      mem[wr_addr] <= bus.wr_rgb;
    end
  end

  // ---------------- stage 1: request register ----------------
  logic              s1_valid;
  logic [BANK_W-1:0] s1_bank;
  logic [IDX_W-1:0]  s1_index;
  logic [LVL_W:0]    s1_level;
  logic [LVL_W:0]    level_q;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      s1_index <= '0;
      s1_level <= LVL_FULL;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_bank  <= bus.pix_bank;
      s1_index <= bus.pix_index;
      s1_level <= level_q;
    end
  end

  // ---------------- stage 2: read, bypass, scale ----------------
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bank_ok;
  logic              wr_hit;
  logic              is_transp;
  logic [RGB_W-1:0]  raw_rgb;

  assign rd_addr    = {s1_bank, s1_index};
  assign rd_bank_ok = 32'(s1_bank) < NUM_BANKS;
  assign wr_hit     = bus.wr_en && wr_bank_ok && (wr_addr == rd_addr);
  assign is_transp  = (TRANSP_EN != 0) && (s1_index == IDX_W'(TRANSP_IDX));

  // A same-cycle write to the entry being read wins over the stored value.
  always_comb begin
    raw_rgb = '0;
    if (rd_bank_ok) begin
      raw_rgb = wr_hit ? bus.wr_rgb : mem[rd_addr];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bus.out_valid   <= 1'b0;
      bus.red         <= '0;
      bus.green       <= '0;
      bus.blue        <= '0;
      bus.transparent <= 1'b0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.transparent <= is_transp;
        if (is_transp) begin
          bus.red   <= '0;
          bus.green <= '0;
          bus.blue  <= '0;
        end else begin
          bus.red   <= scale(raw_rgb[3*CW-1:2*CW], s1_level);
          bus.green <= scale(raw_rgb[2*CW-1:CW],   s1_level);
          bus.blue  <= scale(raw_rgb[CW-1:0],      s1_level);
        end
      end
    end
  end

  // ---------------- fade engine ----------------
  fade_state_t       state, state_n;
  logic [LVL_W:0]    level_n;
  logic [TICK_W-1:0] tick_q, tick_n;
  logic              done_n;
  logic              tick_wrap;

  assign tick_wrap = (32'(tick_q) + 1) == FADE_DIV;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state         <= IDLE;
      level_q       <= LVL_FULL;
      tick_q        <= '0;
      bus.fade_done <= 1'b0;
    end else begin
      state         <= state_n;
      level_q       <= level_n;
      tick_q        <= tick_n;
      bus.fade_done <= done_n;
    end
  end

  // Requests take priority over ticks and restart from the current level.
  always_comb begin
    state_n = state;
    level_n = level_q;
    tick_n  = tick_q;
    done_n  = 1'b0;
    if (bus.fade_out_req) begin
      tick_n = '0;
      if (level_q == '0) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = FADE_OUT;
      end
    end else if (bus.fade_in_req) begin
      tick_n = '0;
      if (level_q == LVL_FULL) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end else begin
        state_n = FADE_IN;
      end
    end else if ((state != IDLE) && bus.frame_tick) begin
      if (tick_wrap) begin
        tick_n = '0;
        if (state == FADE_OUT) begin
          level_n = level_q - 1'b1;
        end else begin
          level_n = level_q + 1'b1;
        end
        if (((state == FADE_OUT) && (level_n == '0)) ||
            ((state == FADE_IN) && (level_n == LVL_FULL))) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end else begin
        tick_n = tick_q + 1'b1;
      end
    end
  end

  assign bus.level     = level_q;
  assign bus.fade_busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_palette_lut_fx.sv
// ------------------------------------------------------------------
// tb_palette_lut_fx : directed vector bench for palette_lut_fx
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_palette_lut_fx;

  localparam int IDX_W     = 4;
  localparam int NUM_BANKS = 3;
  localparam int CW        = 4;
  localparam int LVL_W     = 4;
  localparam int NV        = 9;

  typedef struct {
    logic        do_wr;
    logic [1:0]  wb;
    logic [3:0]  wi;
    logic [11:0] wrgb;
    logic [1:0]  pb;
    logic [3:0]  pi;
    logic [11:0] exp_rgb;
    logic        exp_tr;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   base;
  vec_t vecs [NV];

  palette_lut_fx_if #(.IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS), .CW(CW), .LVL_W(LVL_W)) bus ();

  palette_lut_fx #(
    .IDX_W(IDX_W), .NUM_BANKS(NUM_BANKS), .CW(CW), .LVL_W(LVL_W),
    .FADE_DIV(1), .TRANSP_EN(1), .TRANSP_IDX(0)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && bus.fade_done === 1'b1) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.pix_valid    = 1'b0;
    bus.pix_bank     = '0;
    bus.pix_index    = '0;
    bus.wr_en        = 1'b0;
    bus.wr_bank      = '0;
    bus.wr_index     = '0;
    bus.wr_rgb       = '0;
    bus.frame_tick   = 1'b0;
    bus.fade_out_req = 1'b0;
    bus.fade_in_req  = 1'b0;
  endtask

  task automatic write_entry(input logic [1:0] b, input logic [3:0] i, input logic [11:0] rgb);
    bus.wr_en = 1'b1; bus.wr_bank = b; bus.wr_index = i; bus.wr_rgb = rgb;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic lookup_check(input string name, input logic [1:0] b, input logic [3:0] i,
                              input logic [11:0] exp_rgb, input logic exp_tr);
    bus.pix_valid = 1'b1; bus.pix_bank = b; bus.pix_index = i;
    step();
    bus.pix_valid = 1'b0;
    step();
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'(exp_rgb));
    check({name, "_transp"}, 32'(bus.transparent), 32'(exp_tr));
  endtask

  task automatic pulse_tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd0, 4'd5,  12'hF84, 2'd0, 4'd5,  12'hF84, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 4'd5,  12'h123, 2'd0, 4'd5,  12'hF84, 1'b0};
    vecs[2] = '{1'b0, 2'd0, 4'd0,  12'h000, 2'd1, 4'd5,  12'h123, 1'b0};
    vecs[3] = '{1'b1, 2'd0, 4'd0,  12'hFFF, 2'd0, 4'd0,  12'h000, 1'b1};
    vecs[4] = '{1'b1, 2'd0, 4'd1,  12'h0A5, 2'd0, 4'd1,  12'h0A5, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 4'd5,  12'h777, 2'd3, 4'd5,  12'h000, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 4'd0,  12'h000, 2'd1, 4'd5,  12'h123, 1'b0};
    vecs[7] = '{1'b1, 2'd2, 4'd15, 12'hFED, 2'd2, 4'd15, 12'hFED, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 4'd0,  12'h000, 2'd2, 4'd0,  12'h000, 1'b1};

    Reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    check("rst_valid",  32'(bus.out_valid), 32'd0);
    check("rst_rgb",    32'({bus.red, bus.green, bus.blue}), 32'd0);
    check("rst_transp", 32'(bus.transparent), 32'd0);
    check("rst_level",  32'(bus.level), 32'd16);
    check("rst_busy",   32'(bus.fade_busy), 32'd0);
    check("rst_done",   32'(bus.fade_done), 32'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_wr) write_entry(vecs[i].wb, vecs[i].wi, vecs[i].wrgb);
      lookup_check($sformatf("vec%0d", i), vecs[i].pb, vecs[i].pi, vecs[i].exp_rgb, vecs[i].exp_tr);
    end

    // back-to-back requests
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd0; bus.pix_index = 4'd5;
    step();
    bus.pix_bank = 2'd1; bus.pix_index = 4'd5;
    step();
    check("b2b0_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0F84);
    bus.pix_bank = 2'd0; bus.pix_index = 4'd1;
    step();
    check("b2b1_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0123);
    check("b2b1_valid", 32'(bus.out_valid), 32'd1);
    bus.pix_valid = 1'b0;
    step();
    check("b2b2_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h00A5);
    step();
    check("b2b_end_valid", 32'(bus.out_valid), 32'd0);
    check("b2b_hold_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h00A5);

    // write-through on the stage-2 read cycle
    write_entry(2'd0, 4'd7, 12'h111);
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd0; bus.pix_index = 4'd7;
    step();
    bus.pix_valid = 1'b0;
    bus.wr_en = 1'b1; bus.wr_bank = 2'd0; bus.wr_index = 4'd7; bus.wr_rgb = 12'hABC;
    step();
    bus.wr_en = 1'b0;
    check("wt_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0ABC);
    lookup_check("wt_stored", 2'd0, 4'd7, 12'hABC, 1'b0);
    // a write to a neighbouring entry must not bypass
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd0; bus.pix_index = 4'd5;
    step();
    bus.pix_valid = 1'b0;
    bus.wr_en = 1'b1; bus.wr_bank = 2'd0; bus.wr_index = 4'd6; bus.wr_rgb = 12'h333;
    step();
    bus.wr_en = 1'b0;
    check("wt_miss_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h0F84);

    // fade out 16 -> 8 -> 0
    base = done_cnt;
    bus.fade_out_req = 1'b1;
    step();
    bus.fade_out_req = 1'b0;
    check("fo_busy", 32'(bus.fade_busy), 32'd1);
    check("fo_level_start", 32'(bus.level), 32'd16);
    repeat (8) pulse_tick();
    check("fo_level8", 32'(bus.level), 32'd8);
    check("fo_no_done_mid", 32'(done_cnt - base), 32'd0);
    lookup_check("fo_half", 2'd0, 4'd5, 12'h742, 1'b0);
    repeat (8) pulse_tick();
    check("fo_level0", 32'(bus.level), 32'd0);
    check("fo_idle", 32'(bus.fade_busy), 32'd0);
    check("fo_done_once", 32'(done_cnt - base), 32'd1);
    lookup_check("fo_dark", 2'd0, 4'd5, 12'h000, 1'b0);

    // fade_out at level 0 completes immediately
    bus.fade_out_req = 1'b1;
    step();
    bus.fade_out_req = 1'b0;
    step();
    check("fo_reached_busy", 32'(bus.fade_busy), 32'd0);
    check("fo_reached_done", 32'(done_cnt - base), 32'd2);

    // fade in to full, ticks in IDLE do nothing
    bus.fade_in_req = 1'b1;
    step();
    bus.fade_in_req = 1'b0;
    repeat (16) pulse_tick();
    check("fi_level16", 32'(bus.level), 32'd16);
    check("fi_done", 32'(done_cnt - base), 32'd3);
    repeat (3) pulse_tick();
    check("idle_tick_level", 32'(bus.level), 32'd16);

    // retarget mid fade-out at level 10
    bus.fade_out_req = 1'b1;
    step();
    bus.fade_out_req = 1'b0;
    repeat (6) pulse_tick();
    check("rt_level10", 32'(bus.level), 32'd10);
    bus.fade_in_req = 1'b1; bus.frame_tick = 1'b1;
    step();
    bus.fade_in_req = 1'b0; bus.frame_tick = 1'b0;
    check("rt_level_hold", 32'(bus.level), 32'd10);
    check("rt_busy", 32'(bus.fade_busy), 32'd1);
    repeat (6) pulse_tick();
    check("rt_level16", 32'(bus.level), 32'd16);
    check("rt_idle", 32'(bus.fade_busy), 32'd0);
    check("rt_done", 32'(done_cnt - base), 32'd4);

    // simultaneous requests: fade out wins
    bus.fade_out_req = 1'b1; bus.fade_in_req = 1'b1;
    step();
    bus.fade_out_req = 1'b0; bus.fade_in_req = 1'b0;
    check("both_busy", 32'(bus.fade_busy), 32'd1);
    pulse_tick();
    check("both_level15", 32'(bus.level), 32'd15);

    // reset mid-fade with the pipeline loaded
    bus.pix_valid = 1'b1; bus.pix_bank = 2'd0; bus.pix_index = 4'd5;
    step();
    bus.pix_valid = 1'b0;
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    check("mrst_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'd0);
    check("mrst_level", 32'(bus.level), 32'd16);
    check("mrst_busy", 32'(bus.fade_busy), 32'd0);
    pulse_tick();
    check("mrst_idle_tick", 32'(bus.level), 32'd16);
    lookup_check("mrst_b0", 2'd0, 4'd5, 12'h000, 1'b0);
    lookup_check("mrst_b1", 2'd1, 4'd5, 12'h000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/palette_lut_fx.md
Name: palette_lut_fx

Overview:
Parametrised, runtime-writable colour palette for sprite/background pixel lookup in the VGA pixel path. It replaces fixed per-sprite palette ROMs with one multi-bank palette RAM, selected per pixel, so fighters can share sprite data with alternate colour schemes. It adds a registered two-stage lookup, a transparency flag, and a frame-synchronous fade-out/fade-in brightness engine for round transitions.

Parameters:
IDX_W, 4, palette index width; entries per bank = 2^IDX_W
NUM_BANKS, 2, number of palette banks; BANK_W = max(1, clog2(NUM_BANKS))
CW, 4, bits per colour channel; entry width = 3*CW, packed {R,G,B}
LVL_W, 4, brightness resolution; level range 0..2^LVL_W, where 2^LVL_W = full brightness
FADE_DIV, 2, frame_tick pulses per brightness step (>=1)
TRANSP_EN, 1, 1 = enable the transparent-index flag
TRANSP_IDX, 0, palette index treated as transparent

Ports:
Clk, in, 1, system clock
Reset_n, in, 1, synchronous active-low reset
pix_valid, in, 1, lookup request this cycle
pix_bank, in, BANK_W, bank select for lookup
pix_index, in, IDX_W, palette index for lookup
wr_en, in, 1, palette write strobe
wr_bank, in, BANK_W, bank to write
wr_index, in, IDX_W, entry to write
wr_rgb, in, 3*CW, colour to write {R,G,B}
frame_tick, in, 1, one-cycle pulse per frame (vsync edge)
fade_out_req, in, 1, pulse: start fading toward level 0
fade_in_req, in, 1, pulse: start fading toward full level
out_valid, out, 1, red/green/blue/transparent valid
red, out, CW, scaled red
green, out, CW, scaled green
blue, out, CW, scaled blue
transparent, out, 1, pixel index equals TRANSP_IDX (only when TRANSP_EN=1)
level, out, LVL_W+1, current brightness level
fade_busy, out, 1, fade in progress
fade_done, out, 1, one-cycle pulse when a fade reaches its target

Behaviour:
- Reset (Reset_n=0 at an edge): all palette entries 0; out_valid, red, green, blue, transparent, fade_done, fade_busy = 0; level = 2^LVL_W; FSM = IDLE; tick counter = 0. Reset is synchronous. Reset during a fade or with the pipeline full discards all in-flight state.
- Writes: when wr_en=1, entry [wr_bank][wr_index] takes wr_rgb at that clock edge. A wr_bank >= NUM_BANKS is ignored.
- Lookup pipeline, fixed latency 2:
  - Stage 1 (edge ending cycle N): register pix_valid, pix_bank, pix_index and the current level.
  - Stage 2 (cycle N+1): read the RAM combinationally at the registered address and scale it; outputs are registered at the edge ending N+1 and visible in cycle N+2.
  - One request per cycle, no stalls. out_valid follows pix_valid delayed by 2 cycles.
  - When out_valid=0, colour outputs hold their previous values.
- Write-through: if wr_en=1 in cycle N+1 targets the same bank/index being read by stage 2, the output uses wr_rgb, not the old entry.
- An out-of-range pix_bank produces colour 0 with out_valid still asserted.
- Scaling: each channel out = (c * L) >> LVL_W, where L is the level sampled at stage 1.
  - Product width is CW+LVL_W+1; truncate, no rounding.
  - L = 2^LVL_W gives c unchanged; L = 0 gives 0.
- Transparency: when TRANSP_EN=1 and the registered index == TRANSP_IDX, transparent=1 and the RGB outputs are forced to 0. Otherwise transparent=0.
- Fade FSM states: IDLE, FADE_OUT, FADE_IN.
  - In IDLE: fade_out_req → FADE_OUT, fade_in_req → FADE_IN. If both requests arrive in the same cycle, fade_out wins.
  - A request while a fade is running retargets immediately, starting from the current level, and clears the tick counter.
  - A request for a target already reached (e.g. fade_in_req when level = 2^LVL_W) goes to IDLE and pulses fade_done next cycle.
  - In FADE_OUT/FADE_IN, each frame_tick increments the tick counter. When the counter reaches FADE_DIV, the counter clears and level moves by 1 toward the target.
  - When level reaches the target: state → IDLE, fade_done=1 for exactly one cycle (the cycle after the final step edge). level holds.
  - frame_tick in IDLE has no effect.
  - fade_busy = (state != IDLE).

Test Plan:
- Write bank0 idx5=0xF84, then pix_valid with bank0/idx5 at cycle N → out_valid=1 with R=F, G=8, B=4 at N+2; back-to-back requests on consecutive cycles → outputs on consecutive cycles.
- Write bank1 idx5=0x123, then look up bank0 idx5 and bank1 idx5 → 0xF84 and 0x123 respectively.
- Stage-2 read of idx7 while wr_en writes idx7=0xABC in the same cycle → output 0xABC (write-through).
- TRANSP_EN=1, look up idx0 holding 0xFFF → transparent=1, RGB=000; look up idx1 → transparent=0.
- FADE_DIV=1, LVL_W=4, idx5=0xF84: fade_out_req, then 8 frame_ticks → level=8, output 0x742. After 16 ticks → level=0, output 000, fade_done pulses once, fade_busy=0.
- During a fade_out at level 10, assert fade_in_req together with a tick → level rises back to 16 after 6 further steps, fade_done pulses. Asserting Reset_n=0 mid-fade → level=16, outputs 0, FSM IDLE, all entries 0.
